ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
- Multi-cycle fetch/decode/execute control FSM; sits directly upstream of the ALU and register file.
- Fetches 9-bit instructions from the instruction ROM and decodes opcode bits into the shared op_mne enum.
- Drives the op to the ALU, plus register-write and data-memory strobes and the PC.
- Handles the data-memory handshake for LW/SW, relative branches on the compare flag, and program halt.

Parameters:
- PC_W, 10, program counter / instruction address width.
- INST_W, 9, instruction width; fixed format [8:5] opcode, [4:0] operand.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle pulse; leaves IDLE and begins fetching at PC=0.
- InstAddr  output  PC_W  instruction ROM address (= PC).
- InstIn  input  INST_W  ROM data; registered ROM, valid the cycle after InstAddr is presented.
- Flag  input  1  ALU compare result (EQ/LT/GT), sampled in EXEC of LK.
- MemAck  input  1  data memory completion; single-cycle pulse.
- Op  output  4  op_mne value of current instruction.
- Operand  output  5  IR[4:0]; register index or immediate.
- Exec  output  1  high for exactly one cycle per instruction; ALU result valid.
- RegWrEn  output  1  register file write enable.
- MemRdEn  output  1  data memory read request (LW).
- MemWrEn  output  1  data memory write request (SW).
- PC  output  PC_W  current program counter.
- Done  output  1  high in HALT.
- IllegalOp  output  1  sticky: an opcode of 14 or 15, other than the halt word, was fetched.

Behaviour:
- Reset (async, immediate): state IDLE, PC=0, IR=0.
- Reset values: Op=0 (LK), Operand=0, Exec/RegWrEn/MemRdEn/MemWrEn/Done/IllegalOp=0.
- States: IDLE, FETCH, DECODE, EXEC, MEM_WAIT, HALT.
- IDLE:
  - Start=1 -> FETCH with PC=0.
  - Start is ignored in every other state.
- FETCH: InstAddr=PC; -> DECODE.
- DECODE:
  - IR <= InstIn.
  - IR = all ones (9'h1FF) -> HALT; otherwise -> EXEC.
- EXEC: Exec=1, Op=IR[8:5], Operand=IR[4:0].
  - ADD, SUB, MOV, LOAD, SL, SR, AND, XOR: RegWrEn=1 this cycle; PC <= PC+1; -> FETCH.
  - EQ, LT, GT: no RegWrEn (ALU updates Flag); PC <= PC+1; -> FETCH.
  - LK: if Flag, PC <= PC + sign-extended Operand; else PC <= PC+1; -> FETCH.
  - LW: MemRdEn=1; -> MEM_WAIT.
  - SW: MemWrEn=1; -> MEM_WAIT.
  - Opcode 14/15 (not halt word): treated as NOP; IllegalOp <= 1; PC <= PC+1.
- MEM_WAIT:
  - Hold MemRdEn/MemWrEn, Op and Operand stable.
  - On MemAck=1 (same cycle): LW asserts RegWrEn=1; strobes drop next cycle; PC <= PC+1; -> FETCH.
  - No timeout; waits indefinitely.
  - MemAck outside MEM_WAIT is ignored.
- HALT: Done=1, PC frozen; remains until Reset.
- Timing:
  - Non-memory instruction: 3 cycles (FETCH, DECODE, EXEC).
  - LW/SW: 3 + N cycles, where N ≥ 1 counts MEM_WAIT cycles including the MemAck cycle.
- Arithmetic: all PC updates are modulo 2^PC_W.
  - PC 1023 +1 -> 0.
  - PC 0 with offset -1 -> 1023.
- Signals driven only in EXEC/MEM_WAIT (Exec, RegWrEn, MemRdEn, MemWrEn) are 0 in all other states.
- Op/Operand hold their last value outside EXEC/MEM_WAIT.
- Reset asserted mid-MEM_WAIT drops MemRdEn/MemWrEn in the same cycle; a MemAck arriving afterwards is ignored.

Test Plan:
- Reset then Start; ROM[0]=ADD r3 (9'h043), ROM[1]=9'h1FF -> Exec pulses once at cycle 3 with Op=2, Operand=3, RegWrEn=1; Done=1 after 2nd DECODE; PC=1 frozen.
- LW r5 (9'h0A5), MemAck returned after 3 cycles -> MemRdEn high exactly 3 cycles; RegWrEn=1 only in the MemAck cycle; next fetch at PC+1.
- LK with Operand=5'h1E (−2) at PC=4: Flag=1 -> next InstAddr=2; Flag=0 -> next InstAddr=5.
- Branch wrap: LK Operand=5'h1F at PC=0, Flag=1 -> PC=1023; ADD at PC=1023 -> PC=0.
- Opcode 14 word 9'h1C0 -> no RegWrEn/MemRdEn/MemWrEn, IllegalOp=1 and sticky, PC advances by 1.
- Reset asserted during SW MEM_WAIT -> MemWrEn=0 immediately, state IDLE, PC=0; later MemAck has no effect; Start restarts from 0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ============================================================================
// ctrl_sequencer : fetch/decode/execute control FSM feeding ALU, RF and DMEM
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctrl_sequencer #(
  parameter int PC_W   = 10,
  parameter int INST_W = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic [PC_W-1:0]   InstAddr,
  input  logic [INST_W-1:0] InstIn,
  input  logic              Flag,
  input  logic              MemAck,
  output logic [3:0]        Op,
  output logic [4:0]        Operand,
  output logic              Exec,
  output logic              RegWrEn,
  output logic              MemRdEn,
  output logic              MemWrEn,
  output logic [PC_W-1:0]   PC,
  output logic              Done,
  output logic              IllegalOp
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  // Shared op_mne encoding; 14 and 15 are unassigned.
  typedef enum logic [3:0] {
    OP_LK   = 4'd0,  OP_MOV = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
    OP_LOAD = 4'd4,  OP_LW  = 4'd5,  OP_SW  = 4'd6,  OP_SL  = 4'd7,
    OP_SR   = 4'd8,  OP_AND = 4'd9,  OP_XOR = 4'd10, OP_EQ  = 4'd11,
    OP_LT   = 4'd12, OP_GT  = 4'd13
  } op_mne_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic              illegal_q, illegal_d;

  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_branch;
  op_mne_t           op_cur;

  assign op_cur    = op_mne_t'(ir_q[8:5]);
  assign pc_inc    = pc_q + 1'b1;
  assign pc_branch = pc_q + {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    Exec      = 1'b0;
    RegWrEn   = 1'b0;
    MemRdEn   = 1'b0;
    MemWrEn   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = InstIn;
        state_d = (&InstIn) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        Exec    = 1'b1;
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op_cur)
          OP_ADD, OP_SUB, OP_MOV, OP_LOAD,
          OP_SL, OP_SR, OP_AND, OP_XOR: RegWrEn = 1'b1;
          OP_EQ, OP_LT, OP_GT: ;
          OP_LK: pc_d = Flag ? pc_branch : pc_inc;
          OP_LW: begin
            MemRdEn = 1'b1;
            pc_d    = pc_q;
            state_d = S_MEM_WAIT;
          end
          OP_SW: begin
            MemWrEn = 1'b1;
            pc_d    = pc_q;
            state_d = S_MEM_WAIT;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEM_WAIT: begin
        MemRdEn = (op_cur == OP_LW);
        MemWrEn = (op_cur == OP_SW);
        if (MemAck) begin
          RegWrEn = (op_cur == OP_LW);
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign InstAddr  = pc_q;
  assign PC        = pc_q;
  assign Op        = ir_q[8:5];
  assign Operand   = ir_q[4:0];
  assign Done      = (state_q == S_HALT);
  assign IllegalOp = illegal_q;

endmodule

`default_nettype wire
